// File: rtl/roll_mode_ctrl.sv
// Scope display sequencer: picks triggered-sweep or roll mode, decimates ADC
// samples to one column per timebase period and drives column write strobe/address.
module roll_mode_ctrl #(
    parameter int COLS        = 480,
    parameter int ADDR_W      = 9,
    parameter int DIV_W       = 16,
    parameter int ROLL_THRESH = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DIV_W-1:0]  timebase_div,
    input  logic              roll_en,
    input  logic              trig,
    output logic              sel,
    output logic              col_we,
    output logic [ADDR_W-1:0] col_addr,
    output logic [ADDR_W-1:0] roll_base,
    output logic              frame_done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARM   = 2'b01,
        S_SWEEP = 2'b10,
        S_ROLL  = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0]  THRESH_V = DIV_W'(ROLL_THRESH);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  tb_lat_q, tb_lat_d;
    logic [DIV_W-1:0]  dcnt_q, dcnt_d;
    logic [ADDR_W-1:0] col_ptr_q, col_ptr_d;     // next column to be written
    logic [ADDR_W-1:0] col_addr_q, col_addr_d;   // column shown with col_we
    logic [ADDR_W-1:0] roll_base_q, roll_base_d;
    logic              wrapped_q, wrapped_d;
    logic              sel_q, sel_d;
    logic              col_we_q, col_we_d;
    logic              frame_done_q, frame_done_d;
    logic              roll_en_q, roll_en_d;

    logic              running;
    logic              tick;
    logic              last_col;
    logic [ADDR_W-1:0] ptr_next;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        tb_lat_d     = tb_lat_q;
        dcnt_d       = dcnt_q;
        col_ptr_d    = col_ptr_q;
        col_addr_d   = col_addr_q;
        roll_base_d  = roll_base_q;
        wrapped_d    = wrapped_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        roll_en_d    = roll_en;

        running  = (state_q == S_SWEEP) || (state_q == S_ROLL);
        tick     = running && sample_valid && (dcnt_q == tb_lat_q);
        last_col = (col_ptr_q == LAST_COL);
        ptr_next = last_col ? '0 : col_ptr_q + 1'b1;
        col_we_d = tick;

        if (running && sample_valid) begin
            dcnt_d = tick ? '0 : dcnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tb_lat_d   = timebase_div;
                col_ptr_d  = '0;
                col_addr_d = '0;
                if (roll_en && (timebase_div >= THRESH_V)) begin
                    state_d     = S_ROLL;
                    sel_d       = 1'b1;
                    roll_base_d = '0;
                    wrapped_d   = 1'b0;
                end else begin
                    state_d = S_ARM;
                    sel_d   = 1'b0;
                end
            end
            S_ARM: begin
                if (trig) begin
                    state_d = S_SWEEP;
                end else if (roll_en && !roll_en_q && (timebase_div >= THRESH_V)) begin
                    state_d = S_IDLE;
                end
            end
            S_SWEEP: begin
                if (tick) begin
                    col_addr_d = col_ptr_q;
                    col_ptr_d  = ptr_next;
                    if (last_col) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            S_ROLL: begin
                if (tick) begin
                    col_addr_d = col_ptr_q;
                    col_ptr_d  = ptr_next;
                    // Once every column holds data, the oldest one sits just past the newest.
                    if (wrapped_q || last_col) begin
                        roll_base_d = ptr_next;
                        wrapped_d   = 1'b1;
                    end
                    if (!roll_en) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            dcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            tb_lat_q     <= '0;
            dcnt_q       <= '0;
            col_ptr_q    <= '0;
            col_addr_q   <= '0;
            roll_base_q  <= '0;
            wrapped_q    <= 1'b0;
            sel_q        <= 1'b0;
            col_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            roll_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tb_lat_q     <= tb_lat_d;
            dcnt_q       <= dcnt_d;
            col_ptr_q    <= col_ptr_d;
            col_addr_q   <= col_addr_d;
            roll_base_q  <= roll_base_d;
            wrapped_q    <= wrapped_d;
            sel_q        <= sel_d;
            col_we_q     <= col_we_d;
            frame_done_q <= frame_done_d;
            roll_en_q    <= roll_en_d;
        end
    end

    assign sel        = sel_q;
    assign col_we     = col_we_q;
    assign col_addr   = col_addr_q;
    assign roll_base  = roll_base_q;
    assign frame_done = frame_done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_roll_mode_ctrl.sv
// Directed bench for roll_mode_ctrl; a second instance with a low roll threshold
// makes the 481-column roll wrap reachable in a short run.
module tb_roll_mode_ctrl;

    localparam int ADDR_W = 9;
    localparam int DIV_W  = 16;

    logic              clk;
    logic              reset;
    logic              sample_valid;
    logic [DIV_W-1:0]  timebase_div;
    logic              roll_en;
    logic              trig;

    logic              sel, col_we, frame_done;
    logic [ADDR_W-1:0] col_addr, roll_base;
    logic [1:0]        state;

    logic              r_sel, r_col_we, r_frame_done;
    logic [ADDR_W-1:0] r_col_addr, r_roll_base;
    logic [1:0]        r_state;

    int n_tests;
    int n_failed;

    roll_mode_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .timebase_div (timebase_div),
        .roll_en      (roll_en),
        .trig         (trig),
        .sel          (sel),
        .col_we       (col_we),
        .col_addr     (col_addr),
        .roll_base    (roll_base),
        .frame_done   (frame_done),
        .state        (state)
    );

    roll_mode_ctrl #(.ROLL_THRESH(2)) u_dut_r (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .timebase_div (timebase_div),
        .roll_en      (roll_en),
        .trig         (trig),
        .sel          (r_sel),
        .col_we       (r_col_we),
        .col_addr     (r_col_addr),
        .roll_base    (r_roll_base),
        .frame_done   (r_frame_done),
        .state        (r_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one clock of stimulus, then sample #1 after the edge.
    task automatic step(input logic sv, input logic tg);
        sample_valid = sv;
        trig         = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state"},      32'(state),      32'd0);
        check({tag, " sel"},        32'(sel),        32'd0);
        check({tag, " col_we"},     32'(col_we),     32'd0);
        check({tag, " col_addr"},   32'(col_addr),   32'd0);
        check({tag, " roll_base"},  32'(roll_base),  32'd0);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        n_tests      = 0;
        n_failed     = 0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        trig         = 1'b0;
        roll_en      = 1'b0;
        timebase_div = 16'd0;

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_reset_outputs("por");

        // Triggered sweep, tb=0: one column per sample.
        reset = 1'b0;
        step(1'b0, 1'b0);
        check("arm_state", 32'(state), 32'd1);
        check("arm_sel",   32'(sel),   32'd0);
        step(1'b0, 1'b1);
        check("sweep_entry", 32'(state), 32'd2);
        check("sweep_entry_we", 32'(col_we), 32'd0);
        for (int i = 0; i < 480; i++) begin
            step(1'b1, 1'b0);
            check("tb0_we",   32'(col_we),     32'd1);
            check("tb0_addr", 32'(col_addr),   32'(i));
            check("tb0_fd",   32'(frame_done), (i == 479) ? 32'd1 : 32'd0);
        end
        check("tb0_end_idle", 32'(state), 32'd0);
        step(1'b0, 1'b0);
        check("tb0_rearm",      32'(state),    32'd1);
        check("tb0_rearm_sel",  32'(sel),      32'd0);
        check("tb0_rearm_we",   32'(col_we),   32'd0);
        check("tb0_rearm_addr", 32'(col_addr), 32'd0);

        // Reset held 3 clocks mid-sweep.
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("pre_reset_addr", 32'(col_addr), 32'd4);
        reset = 1'b1;
        step(1'b1, 1'b0);
        check_reset_outputs("mid_rst1");
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check_reset_outputs("mid_rst3");

        // tb=3, trig+sample in the same ARM cycle; tb change mid-sweep ignored.
        timebase_div = 16'd3;
        reset        = 1'b0;
        step(1'b0, 1'b0);
        check("tb3_arm", 32'(state), 32'd1);
        step(1'b1, 1'b1);
        check("tb3_sweep", 32'(state),  32'd2);
        check("tb3_trig_we", 32'(col_we), 32'd0);
        for (int n = 1; n <= 1920; n++) begin
            if (n == 5) timebase_div = 16'd7;
            step(1'b1, 1'b0);
            check("tb3_we", 32'(col_we), (n % 4 == 0) ? 32'd1 : 32'd0);
            if (n % 4 == 0) check("tb3_addr", 32'(col_addr), 32'(n / 4 - 1));
            check("tb3_fd", 32'(frame_done), (n == 1920) ? 32'd1 : 32'd0);
        end
        check("tb3_end_idle", 32'(state), 32'd0);
        step(1'b0, 1'b0);
        check("tb7_arm", 32'(state), 32'd1);
        step(1'b0, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            step(1'b1, 1'b0);
            check("tb7_we", 32'(col_we), (n == 8) ? 32'd1 : 32'd0);
        end
        check("tb7_addr", 32'(col_addr), 32'd0);

        // Roll mode via roll_en rising in ARM, tb=1000.
        reset        = 1'b1;
        roll_en      = 1'b0;
        timebase_div = 16'd1000;
        step(1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0);
        check("roll_pre_arm", 32'(state), 32'd1);
        roll_en = 1'b1;
        step(1'b0, 1'b0);
        check("roll_rise_idle", 32'(state), 32'd0);
        step(1'b0, 1'b0);
        check("roll_state", 32'(state), 32'd3);
        check("roll_sel",   32'(sel),   32'd1);
        for (int n = 1; n <= 2002; n++) begin
            step(1'b1, 1'b0);
            check("roll_we", 32'(col_we), (n % 1001 == 0) ? 32'd1 : 32'd0);
            if (n % 1001 == 0) check("roll_addr", 32'(col_addr), 32'(n / 1001 - 1));
        end
        check("roll_base_prewrap", 32'(roll_base), 32'd0);
        roll_en = 1'b0;
        for (int n = 1; n <= 1001; n++) begin
            step(1'b1, 1'b0);
            check("roll_exit_state", 32'(state), (n == 1001) ? 32'd0 : 32'd3);
            check("roll_exit_we", 32'(col_we), (n == 1001) ? 32'd1 : 32'd0);
        end
        check("roll_exit_addr", 32'(col_addr), 32'd2);
        check("roll_exit_sel_held", 32'(sel), 32'd1);
        step(1'b0, 1'b0);
        check("roll_exit_arm", 32'(state), 32'd1);
        check("roll_exit_sel", 32'(sel),   32'd0);

        // Roll wrap on the low-threshold instance, tb=2: 3 samples per column.
        reset        = 1'b1;
        roll_en      = 1'b1;
        timebase_div = 16'd2;
        step(1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0);
        check("wrap_state", 32'(r_state), 32'd3);
        check("wrap_sel",   32'(r_sel),   32'd1);
        for (int n = 1; n <= 1443; n++) begin
            step(1'b1, 1'b0);
            check("wrap_we", 32'(r_col_we), (n % 3 == 0) ? 32'd1 : 32'd0);
            if (n % 3 == 0) begin
                check("wrap_addr", 32'(r_col_addr), 32'((n / 3 - 1) % 480));
                check("wrap_base", 32'(r_roll_base), (n / 3 >= 480) ? 32'((n / 3) % 480) : 32'd0);
            end
        end
        check("wrap481_addr", 32'(r_col_addr),  32'd0);
        check("wrap481_base", 32'(r_roll_base), 32'd1);
        check("wrap481_sel",  32'(r_sel),       32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
